// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, reset PC,
// PC increment and the {pc, instr} entry layout handed to decode.
package mips_fetch_pkg;

  localparam int ADDR_W_D = 32;
  localparam int DATA_W_D = 32;
  localparam logic [31:0] RESET_PC_D = 32'h0000_0000;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [ADDR_W_D-1:0] pc;
    logic [DATA_W_D-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and same-cycle push/pop. Pushing into a full FIFO
// is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = bump(wr_q);
      if (do_pop)  rd_d = bump(rd_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests to imem, epoch-tagged in-order
// responses, and a small buffer presenting {pc, instr} to decode.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_D)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] current_pc,
  output logic [ADDR_W-1:0] next_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  input  logic              if_ready
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int TAG_W = ADDR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic             epoch_q, epoch_d;
  logic             tag_full, tag_empty, buf_full, buf_empty;
  logic [CNT_W-1:0] tag_cnt, buf_cnt;
  logic [CNT_W:0]   occupancy;
  logic [TAG_W-1:0] tag_head;
  logic [ENT_W-1:0] buf_head;
  logic             fire, resp_ok, tag_live, buf_push, buf_pop;

  // In-flight plus buffered never exceeds BUF_DEPTH, so every response has a slot.
  assign occupancy      = {1'b0, tag_cnt} + {1'b0, buf_cnt};
  assign imem_req_valid = rst && !redirect_valid && (occupancy < (CNT_W + 1)'(BUF_DEPTH));
  assign imem_req_addr  = current_pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign resp_ok  = imem_resp_valid && !tag_empty;
  assign tag_live = (tag_head[0] == epoch_q);
  assign buf_pop  = if_valid && if_ready;
  assign buf_push = resp_ok && tag_live && !redirect_valid && (!buf_full || buf_pop);

  assign if_valid           = rst && !buf_empty;
  assign {if_pc, if_instr}  = buf_head;
  assign epoch_d            = epoch_q ^ redirect_valid;

  always_comb begin
    next_pc = current_pc;
    if (!rst)                next_pc = RESET_PC;
    else if (redirect_valid) next_pc = redirect_pc;
    else if (fire)           next_pc = current_pc + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst) epoch_q <= 1'b0;
    else      epoch_q <= epoch_d;
  end

  // Tag queue pops on every accepted response, even in a redirect cycle.
  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(TAG_W), .CNT_W(CNT_W)) u_tag_q (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (1'b0),
    .push_i  (fire && !tag_full),
    .data_i  ({current_pc, epoch_q}),
    .pop_i   (resp_ok),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );

  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(ENT_W), .CNT_W(CNT_W)) u_ibuf (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect_valid),
    .push_i  (buf_push),
    .data_i  ({tag_head[TAG_W-1:1], imem_resp_data}),
    .pop_i   (buf_pop),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, per-cycle output compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;
  import mips_fetch_pkg::*;

  logic        clk, rst;
  logic [31:0] current_pc, next_pc, redirect_pc, imem_req_addr, imem_resp_data;
  logic [31:0] if_pc, if_instr;
  logic        redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic        if_valid, if_ready;

  fetch_unit dut (
    .clk(clk), .rst(rst), .current_pc(current_pc), .next_pc(next_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_ready(if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit ep; } tag_t;
  typedef struct { logic [31:0] data; int due; } mreq_t;

  int checks = 0, errors = 0, cyc = 0, last_due = 0;
  bit go = 0;
  tag_t         tagq[$];
  fetch_entry_t bufq[$], accepted[$];
  mreq_t        memq[$];
  bit           epoch = 0;
  logic [31:0]  pc_reg = 32'h0;

  bit k_rst = 0, k_redir = 0, k_rdy = 1, k_ifr = 1, k_spur = 0, k_pcovr = 0, k_rdata = 0;
  logic [31:0] k_rpc = 0, k_pcval = 0;
  int lat_lo = 1, lat_hi = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit e_reqv();
    return rst && !redirect_valid && (tagq.size() + bufq.size() < 2);
  endfunction

  function automatic logic [31:0] e_next();
    if (!rst) return 32'h0;
    if (redirect_valid) return redirect_pc;
    if (e_reqv() && imem_req_ready) return current_pc + 32'd4;
    return current_pc;
  endfunction

  function automatic bit e_ifv();
    return rst && (bufq.size() > 0);
  endfunction

  // Reference model: advances the architectural queues once per clock edge.
  always @(posedge clk) begin : model
    logic [31:0] nx;
    bit fire, resp_ok, pop, ep0;
    tag_t t;
    fetch_entry_t e;
    mreq_t m;
    nx = e_next();
    if (!rst) begin
      tagq.delete(); bufq.delete(); memq.delete(); epoch = 0;
    end else begin
      fire    = e_reqv() && imem_req_ready;
      resp_ok = imem_resp_valid && (tagq.size() > 0);
      pop     = (bufq.size() > 0) && if_ready;
      ep0     = epoch;
      t       = '{pc: 32'h0, ep: 1'b0};
      if (resp_ok) t = tagq.pop_front();
      if (redirect_valid) begin
        bufq.delete();
        epoch = !epoch;
      end else begin
        if (pop) accepted.push_back(bufq.pop_front());
        if (resp_ok && t.ep == epoch) begin
          e.pc = t.pc; e.instr = imem_resp_data;
          bufq.push_back(e);
        end
      end
      if (fire) begin
        tagq.push_back('{pc: current_pc, ep: ep0});
        m.data = k_rdata ? $urandom : 32'h2000_0000 + current_pc;
        m.due  = cyc + $urandom_range(lat_hi, lat_lo);
        if (m.due <= last_due) m.due = last_due + 1;
        last_due = m.due;
        memq.push_back(m);
      end
    end
    pc_reg = nx;
    cyc++;
  end

  always @(negedge clk) begin
    if (go) begin
      chk("next_pc", next_pc, e_next());
      chk("imem_req_valid", imem_req_valid, e_reqv());
      chk("imem_req_addr", imem_req_addr, current_pc);
      chk("if_valid", if_valid, e_ifv());
      if (e_ifv()) begin
        chk("if_pc", if_pc, bufq[0].pc);
        chk("if_instr", if_instr, bufq[0].instr);
      end
    end
  end

  task automatic apply();
    mreq_t m;
    rst = k_rst; redirect_valid = k_redir; redirect_pc = k_rpc;
    imem_req_ready = k_rdy; if_ready = k_ifr;
    if (k_pcovr) pc_reg = k_pcval;
    current_pc = pc_reg;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = m.data;
    end else if (k_spur && memq.size() == 0) begin
      imem_resp_valid = 1'b1;
    end
    #2;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin apply(); adv(); end
  endtask

  initial begin
    int found, brk;
    // Reset held with current_pc=0x40.
    k_rst = 0; k_pcovr = 1; k_pcval = 32'h40;
    apply(); go = 1; adv();
    for (int i = 0; i < 3; i++) begin
      apply();
      chk("rst_next_pc", next_pc, 32'h0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      adv();
    end
    // Release: first request at 0x40, 1-cycle memory, decode always ready.
    k_rst = 1; apply();
    chk("first_req_addr", imem_req_addr, 32'h40);
    chk("first_next_pc", next_pc, 32'h44);
    chk("first_req_valid", imem_req_valid, 1);
    adv(); k_pcovr = 0;
    run(1);
    apply();
    chk("lat_if_valid", if_valid, 1);
    chk("lat_if_pc", if_pc, 32'h40);
    chk("lat_if_instr", if_instr, 32'h2000_0040);
    chk("credit_full_req", imem_req_valid, 0);
    adv();
    run(10);
    chk("stream_count", accepted.size() >= 4, 1);
    if (accepted.size() >= 4) begin
      chk("stream_pc0", accepted[0].pc, 32'h40);
      chk("stream_pc1", accepted[1].pc, 32'h44);
      chk("stream_pc2", accepted[2].pc, 32'h48);
      chk("stream_pc3", accepted[3].pc, 32'h4C);
    end
    // Decode stall: credits run out, head held.
    k_ifr = 0; run(6);
    apply();
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_if_valid", if_valid, 1);
    adv();
    k_ifr = 1; run(12);
    brk = 0;
    foreach (accepted[i]) begin
      if (accepted[i].instr != 32'h2000_0000 + accepted[i].pc) brk++;
      if (i > 0 && accepted[i].pc != accepted[i-1].pc + 32'd4) brk++;
    end
    chk("stall_no_loss_dup", brk, 0);
    chk("stall_count", accepted.size() >= 8, 1);
    // Redirect with two stale requests outstanding, 3-cycle memory.
    lat_lo = 3; lat_hi = 3; found = 0;
    for (int i = 0; i < 20; i++) begin
      if (tagq.size() == 2) begin found = 1; break; end
      run(1);
    end
    chk("redir_setup_found", found, 1);
    k_redir = 1; k_rpc = 32'h100; apply();
    chk("redir_next_pc", next_pc, 32'h100);
    chk("redir_req_valid", imem_req_valid, 0);
    accepted.delete(); adv(); k_redir = 0;
    for (int i = 0; i < 30 && accepted.size() == 0; i++) run(1);
    chk("redir_seen", accepted.size() > 0, 1);
    if (accepted.size() > 0) chk("redir_first_pc", accepted[0].pc, 32'h100);
    // Redirect coinciding with a response and a decode pop.
    lat_lo = 1; lat_hi = 1; found = 0;
    for (int i = 0; i < 40; i++) begin
      if (bufq.size() > 0 && memq.size() > 0 && memq[0].due <= cyc) begin found = 1; break; end
      run(1);
    end
    chk("coinc_setup_found", found, 1);
    k_redir = 1; k_rpc = 32'h200; apply(); accepted.delete(); adv(); k_redir = 0;
    apply();
    chk("coinc_flushed", if_valid, 0);
    adv();
    for (int i = 0; i < 30 && accepted.size() == 0; i++) run(1);
    chk("coinc_seen", accepted.size() > 0, 1);
    if (accepted.size() > 0) chk("coinc_first_pc", accepted[0].pc, 32'h200);
    // Wrap at the top of the address space with memory backpressure.
    k_redir = 1; k_rpc = 32'hFFFF_FFFC; k_rdy = 0; apply(); accepted.delete(); adv(); k_redir = 0;
    for (int i = 0; i < 4; i++) begin
      apply();
      chk("wrap_hold_next_pc", next_pc, 32'hFFFF_FFFC);
      adv();
    end
    k_rdy = 1; found = 0;
    for (int i = 0; i < 10; i++) begin
      if (tagq.size() + bufq.size() < 2) begin found = 1; break; end
      run(1);
    end
    chk("wrap_credit_found", found, 1);
    apply();
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_next_pc", next_pc, 32'h0);
    adv();
    run(10);
    chk("wrap_count", accepted.size() >= 2, 1);
    if (accepted.size() >= 2) begin
      chk("wrap_pc0", accepted[0].pc, 32'hFFFF_FFFC);
      chk("wrap_pc1", accepted[1].pc, 32'h0);
    end
    // Spurious response right after reset must be ignored.
    k_rst = 0; run(1);
    k_rst = 1; k_rdy = 0; k_spur = 1; run(1);
    k_spur = 0; apply();
    chk("spur_ignored", if_valid, 0);
    adv();
    // Randomized traffic including resets, redirects and spurious responses.
    k_rdata = 1; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      k_rst   = ($urandom_range(0, 299) != 0);
      k_redir = ($urandom_range(0, 15) == 0);
      k_rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      k_rdy   = ($urandom_range(0, 3) != 0);
      k_ifr   = ($urandom_range(0, 2) != 0);
      k_spur  = ($urandom_range(0, 7) == 0);
      run(1);
    end
    go = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
